// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: parity mode codes, Tx FSM state
//                encoding and a frame-length helper for the Tx and Rx blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode codes for the PARITY_MODE parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Tx FSM state encoding
    localparam int TX_STATE_W = 3;
    typedef logic [TX_STATE_W-1:0] tx_state_t;

    localparam tx_state_t TX_IDLE   = 3'd0;
    localparam tx_state_t TX_START  = 3'd1;
    localparam tx_state_t TX_DATA   = 3'd2;
    localparam tx_state_t TX_PARITY = 3'd3;
    localparam tx_state_t TX_STOP   = 3'd4;

    // Clock cycles from the first start-bit cycle to the end of the last
    // stop-bit cycle.
    function automatic int frame_clks(input int data_width,
                                      input int clks_per_bit,
                                      input int parity_mode,
                                      input int stop_bits);
        return (1 + data_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits)
               * clks_per_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_counter
//  Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the
//                final cycle of each serial bit.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-high reset
//                restart  - hold/restart the count at 0
//                bit_tick - high on the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_counter: CLKS_PER_BIT must be at least 2");
    end

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_cnt_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_tick = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : Parametrised UART transmit serializer. Takes one word per
//                valid/ready handshake and sends start, DATA_WIDTH data bits
//                LSB first, optional parity and 1 or 2 stop bits on o_tx.
//  Ports       : clk     - system clock
//                reset   - asynchronous active-high reset
//                i_valid - i_data holds a word to send
//                o_ready - a word can be accepted this cycle
//                i_data  - parallel word to send
//                o_tx    - serial line, idle high (registered)
//                o_busy  - frame in progress
//                o_done  - pulse in the last cycle of the final stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_serializer: DATA_WIDTH must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int c_idx_w = $clog2(DATA_WIDTH);
    localparam logic [c_idx_w-1:0] c_last_bit  = c_idx_w'(DATA_WIDTH - 1);
    localparam logic               c_last_stop = 1'(STOP_BITS - 1);

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic [c_idx_w-1:0]    r_bit_idx;
    logic                  r_stop_idx;

    logic w_tick;
    logic w_last_stop;
    logic w_accept;
    logic w_parity;
    logic w_restart;

    // Counter is parked at 0 while idle and re-aligned on every accept, so
    // the start bit always lasts exactly CLKS_PER_BIT cycles.
    assign w_restart = w_accept || (r_state == TX_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_restart),
        .bit_tick (w_tick)
    );

    assign w_last_stop = (r_state == TX_STOP) && w_tick && (r_stop_idx == c_last_stop);
    assign o_ready     = (r_state == TX_IDLE) || w_last_stop;
    assign o_done      = w_last_stop;
    assign o_busy      = (r_state != TX_IDLE);
    assign o_tx        = r_tx;
    assign w_accept    = i_valid && o_ready;

    assign w_parity = (PARITY_MODE == PARITY_ODD) ? ~(^i_data) : (^i_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                end
                TX_START: begin
                    if (w_tick) begin
                        r_state   <= TX_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_last_bit) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                r_state <= TX_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= TX_STOP;
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_tick) begin
                        r_state    <= TX_STOP;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_stop_idx == c_last_stop) begin
                            r_state <= TX_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase

            // Accept overrides the state update above; in the final stop
            // cycle this chains straight into the next start bit.
            if (w_accept) begin
                r_state    <= TX_START;
                r_tx       <= 1'b0;
                r_shift    <= i_data;
                r_parity   <= w_parity;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer. It is the successor of the fixed 9-bit PISO Tx shift register.
- Accepts one parallel word per valid/ready handshake and emits a complete frame on o_tx: start bit, DATA_WIDTH data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- An internal baud counter holds each bit for CLKS_PER_BIT clocks.
- Sits between the Tx data source (FIFO or CPU register) and the serial pin.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_valid  in  1  i_data is valid
o_ready  out  1  serializer can accept a word this cycle
i_data  in  DATA_WIDTH  parallel word to transmit
o_tx  out  1  serial line, idle high
o_busy  out  1  frame in progress (start through final stop bit)
o_done  out  1  one-cycle pulse in the last clk of the final stop bit

Behaviour:
- One clock; reset is asynchronous and active-high.
- While reset is high: o_tx=1, o_ready=1, o_busy=0, o_done=0, state=IDLE, counters=0. These values apply immediately, including mid-frame; the partial frame is abandoned.
- All outputs are registered or decoded from registered state only; o_tx must never glitch.
- Accept: on a clk edge with i_valid && o_ready.
  - Capture i_data into the shift register.
  - Compute parity from the captured word: even = XOR of bits; odd = inverted XOR.
  - i_data is ignored whenever o_ready=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1, o_ready=1, o_busy=0. Accept -> START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, starting the cycle after accept. Then -> DATA.
  - DATA: shift out bit 0 first, DATA_WIDTH bits, each CLKS_PER_BIT cycles. Bit index counter runs 0..DATA_WIDTH-1. Then -> PARITY if PARITY_MODE!=0, else -> STOP.
  - PARITY: o_tx=parity bit for CLKS_PER_BIT cycles. Then -> STOP.
  - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Last cycle of final stop bit:
  - o_done=1 and o_ready=1.
  - If i_valid=1, accept and go directly to START: back-to-back frames with no idle cycle.
  - Otherwise go to IDLE.
- o_busy=1 in START, DATA, PARITY and STOP. It stays 1 across back-to-back frames.
- Frame length = (1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT clk cycles, measured from the first start-bit cycle to the end of the last stop-bit cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1; the bit advances on wrap. The counter restarts at 0 on every accept.
- Illegal parameters (DATA_WIDTH outside 5..9, CLKS_PER_BIT<2, PARITY_MODE>2, STOP_BITS not 1 or 2) must fail elaboration.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE/PARITY_EVEN/PARITY_ODD constants.
  - Tx FSM state encoding.
  - Frame-length helper function, reused by the future Rx block.
- One sub-module: uart_baud_counter.
  - Parameter: CLKS_PER_BIT.
  - Inputs: clk, reset, restart.
  - Output: bit_tick, which pulses on the last cycle of each bit.

Test Plan:
1. Assert reset for 3 cycles, then release -> o_tx=1, o_ready=1, o_busy=0, o_done=0; no activity with i_valid=0 for 100 cycles.
2. Configuration 8N1, CLKS_PER_BIT=4: send 0xA5 -> o_tx holds each of 0 | 1,0,1,0,0,1,0,1 | 1 for 4 cycles; o_done pulses in cycle 40 after accept; o_ready low for cycles 1..39.
3. Even parity: send 0x07 -> parity bit 1. Odd parity: send 0x07 -> parity bit 0. 8E2: frame = 48 cycles at CLKS_PER_BIT=4.
4. Hold i_valid high with 0x55 then 0xAA -> second start bit begins the cycle after the first frame's o_done; no extra idle cycle; o_busy never drops.
5. Assert reset during DATA bit 3 of 0xF0 -> o_tx=1 without waiting for a clk edge; after release, o_ready=1; a new 0x3C frame is transmitted correctly.
6. Pulse i_valid with 0xFF during DATA of an 0x00 frame -> ignored; exactly one frame on o_tx and one o_done pulse.
